// File: rtl/meas_gen_pkg.sv
// meas_pkg: types and coefficient tables for the 4x4 compressive measurement generator.
// Rev 1.0
`default_nettype none

package meas_pkg;

  localparam int BLK_N     = 4;
  localparam int PIX_N     = BLK_N * BLK_N;
  localparam int MEA_N     = PIX_N / 2;
  localparam int PIX_WID   = 8;
  localparam int MEA_WID   = $clog2(PIX_N) + PIX_WID;
  localparam int PIC_WID   = 13;
  localparam int PIC_HT    = 13;
  localparam int COR_X_WID = PIC_WID - $clog2(BLK_N);
  localparam int COR_Y_WID = PIC_HT - $clog2(BLK_N);

  typedef logic signed [1:0]             coef_t;
  typedef logic signed [MEA_WID:0]       meas_t;
  typedef logic [BLK_N-1:0][PIX_WID-1:0] pix_row_t;
  typedef logic [COR_X_WID-1:0]          blk_coord_t;

  // Basis row vectors h0..h3; each measurement picks one for columns and one for rows.
  localparam coef_t H_VEC [BLK_N][BLK_N] = '{
    '{2'sb01, 2'sb01, 2'sb01, 2'sb01},
    '{2'sb01, 2'sb00, 2'sb00, 2'sb11},
    '{2'sb01, 2'sb11, 2'sb11, 2'sb01},
    '{2'sb00, 2'sb11, 2'sb01, 2'sb00}
  };
  localparam int HC_SEL [MEA_N] = '{0, 1, 2, 3, 0, 1, 0, 0};
  localparam int HR_SEL [MEA_N] = '{0, 0, 0, 0, 1, 1, 2, 3};

  function automatic meas_t apply_coef(input coef_t k, input meas_t v);
    case (k)
      2'sb01:  return v;
      2'sb11:  return -v;
      default: return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/meas_gen_row_mac.sv
// meas_row_mac: combinational column-weighted sum of one block row for every measurement.
// Rev 1.0
`default_nettype none

module meas_row_mac
  import meas_pkg::*;
(
  input  pix_row_t pix,
  output meas_t    row_sum [MEA_N]
);

  for (genvar m = 0; m < MEA_N; m++) begin : g_meas
    meas_t part [BLK_N+1];
    assign part[0] = '0;
    for (genvar c = 0; c < BLK_N; c++) begin : g_col
      assign part[c+1] = part[c] + apply_coef(H_VEC[HC_SEL[m]][c],
                                              {{(MEA_WID-PIX_WID+1){1'b0}}, pix[c]});
    end
    assign row_sum[m] = part[BLK_N];
  end

endmodule

`default_nettype wire

// File: rtl/meas_gen.sv
// meas_gen: accumulates four pixel rows per 4x4 block into eight signed measurements
// and hands them out with block coordinates. Rev 1.0
`default_nettype none

module meas_gen
  import meas_pkg::*;
(
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  pix_row_t             pix,
  input  blk_coord_t           pic_w_blk,
  input  logic [COR_Y_WID-1:0] pic_h_blk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output meas_t                y [MEA_N],
  output blk_coord_t           cor_X,
  output logic [COR_Y_WID-1:0] cor_Y,
  output logic                 out_eof
);

  logic [1:0]           row_cnt_q, row_cnt_d;
  blk_coord_t           bx_q, bx_d;
  logic [COR_Y_WID-1:0] by_q, by_d;
  meas_t                acc_q [MEA_N];
  meas_t                acc_d [MEA_N];
  meas_t                y_q   [MEA_N];
  meas_t                y_d   [MEA_N];
  blk_coord_t           cor_x_q, cor_x_d;
  logic [COR_Y_WID-1:0] cor_y_q, cor_y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_eof_q, out_eof_d;

  logic       accept;
  logic       last;
  logic [1:0] row_eff;
  meas_t      row_sum  [MEA_N];
  meas_t      acc_next [MEA_N];

  // Only the block-closing row can be held off by a pending result.
  assign in_ready = (row_cnt_q != 2'd3) || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign row_eff  = in_sof ? 2'd0 : row_cnt_q;
  assign last     = accept && (row_eff == 2'd3);

  meas_row_mac u_row_mac (
    .pix     (pix),
    .row_sum (row_sum)
  );

  for (genvar m = 0; m < MEA_N; m++) begin : g_acc
    meas_t contrib;
    assign contrib     = apply_coef(H_VEC[HR_SEL[m]][row_eff], row_sum[m]);
    assign acc_next[m] = (row_eff == 2'd0) ? contrib : acc_q[m] + contrib;
  end

  always_comb begin
    row_cnt_d   = row_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    acc_d       = acc_q;
    y_d         = y_q;
    cor_x_d     = cor_x_q;
    cor_y_d     = cor_y_q;
    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;

    if (out_ready) out_valid_d = 1'b0;

    if (accept) begin
      row_cnt_d = row_eff + 2'd1;
      acc_d     = acc_next;
      if (in_sof) begin
        bx_d = '0;
        by_d = '0;
      end
    end

    if (last) begin
      y_d         = acc_next;
      cor_x_d     = bx_q;
      cor_y_d     = by_q;
      out_valid_d = 1'b1;
      out_eof_d   = 1'b0;
      if (bx_q == pic_w_blk) begin
        bx_d = '0;
        if (by_q == pic_h_blk) begin
          by_d      = '0;
          out_eof_d = 1'b1;
        end else begin
          by_d = by_q + 1'b1;
        end
      end else begin
        bx_d = bx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      row_cnt_q   <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      acc_q       <= '{default: '0};
      y_q         <= '{default: '0};
      cor_x_q     <= '0;
      cor_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      cor_x_q     <= cor_x_d;
      cor_y_q     <= cor_y_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cor_X     = cor_x_q;
  assign cor_Y     = cor_y_q;
  assign out_eof   = out_eof_q;

endmodule

`default_nettype wire

// File: tb/tb_meas_gen.sv
// tb_meas_gen: directed stimulus with a scoreboard queue checked by an independent monitor.
// Rev 1.0
`default_nettype none

module tb_meas_gen;
  import meas_pkg::*;

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  pix_row_t             pix;
  blk_coord_t           pic_w_blk;
  logic [COR_Y_WID-1:0] pic_h_blk;
  logic                 out_valid;
  logic                 out_ready;
  meas_t                y [MEA_N];
  blk_coord_t           cor_X;
  logic [COR_Y_WID-1:0] cor_Y;
  logic                 out_eof;

  meas_gen dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .pix       (pix),
    .pic_w_blk (pic_w_blk),
    .pic_h_blk (pic_h_blk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cor_X     (cor_X),
    .cor_Y     (cor_Y),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y [8];
    int cx;
    int cy;
    int eof;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  // Hand-computed measurement vectors for the six pixel patterns below.
  int ey [6][8] = '{
    '{2048,     0,    0,  0,   0,   0,   0,  0},
    '{ 240,  -120,    0, 40,   0,   0,   0,  0},
    '{ 136,   -12,    0,  4, -48,   0,   0, 16},
    '{ 510,     0,  510,  0,   0, 510, 510,  0},
    '{1020, -1020, 1020,  0,   0,   0,   0,  0},
    '{4080,     0,    0,  0,   0,   0,   0,  0}
  };

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic pix_row_t row_of(input int p, input int r);
    pix_row_t v;
    for (int c = 0; c < BLK_N; c++) begin
      case (p)
        0:       v[c] = 8'd128;
        1:       v[c] = 8'(10 * c);
        2:       v[c] = 8'(4 * r + c + 1);
        3:       v[c] = ((r == 0 && c == 0) || (r == 3 && c == 3)) ? 8'd255 : 8'd0;
        4:       v[c] = (c == 3) ? 8'd255 : 8'd0;
        default: v[c] = 8'd255;
      endcase
    end
    return v;
  endfunction

  task automatic send_row(input pix_row_t p, input bit sof, output int waited);
    bit rdy;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    pix      = p;
    forever begin
      #2 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        chk("row_handshake_timeout", waited, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_block(input int p, input bit sof, input int cx, input int cy,
                            input int eof, input bit lat_chk, input bit bp_chk);
    exp_t e;
    int   w;
    for (int m = 0; m < 8; m++) e.y[m] = ey[p][m];
    e.cx  = cx;
    e.cy  = cy;
    e.eof = eof;
    sb.push_back(e);
    for (int r = 0; r < BLK_N; r++) begin
      if (lat_chk && r == 3) begin
        #2 chk("valid_before_row3", int'(out_valid), 0);
      end
      send_row(row_of(p, r), sof && (r == 0), w);
      if (bp_chk) chk($sformatf("bp_row%0d_stalled", r), int'(w > 0), int'(r == 3));
    end
    idle_inputs();
    if (lat_chk) begin
      #2 chk("valid_one_cycle_after_row3", int'(out_valid), 1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: compares the oldest expected entry whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (arst_n && out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb[0];
          for (int m = 0; m < MEA_N; m++) chk($sformatf("y%0d", m), int'(y[m]), e.y[m]);
          chk("cor_X", int'(cor_X), e.cx);
          chk("cor_Y", int'(cor_Y), e.cy);
          chk("out_eof", int'(out_eof), e.eof);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    pix       = '0;
    out_ready = 1'b1;
    pic_w_blk = 11'd2;
    pic_h_blk = 11'd1;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_eof", int'(out_eof), 0);
    chk("reset_cor_X", int'(cor_X), 0);
    chk("reset_y0", int'(y[0]), 0);
    @(negedge clk);
    arst_n = 1'b1;
    #2 chk("in_ready_after_reset", int'(in_ready), 1);

    // Raster walk 3x2 blocks, then wrap.
    send_block(0, 1'b1, 0, 0, 0, 1'b1, 1'b0);
    send_block(1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
    send_block(2, 1'b0, 2, 0, 0, 1'b0, 1'b0);
    send_block(3, 1'b0, 0, 1, 0, 1'b0, 1'b0);
    send_block(4, 1'b0, 1, 1, 0, 1'b0, 1'b0);
    send_block(5, 1'b0, 2, 1, 1, 1'b0, 1'b0);
    send_block(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    wait_drain();

    // Back-pressure: hold the first result while a second block streams.
    @(negedge clk);
    out_ready = 1'b0;
    send_block(1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
    fork
      send_block(2, 1'b0, 2, 0, 0, 1'b0, 1'b1);
      begin
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Start-of-frame mid-block discards the partial accumulation.
    send_row(row_of(5, 0), 1'b0, w);
    send_row(row_of(5, 1), 1'b0, w);
    send_block(2, 1'b1, 0, 0, 0, 1'b0, 1'b0);
    wait_drain();

    // Asynchronous reset after two rows drops the block and clears outputs.
    send_row(row_of(5, 0), 1'b0, w);
    send_row(row_of(5, 1), 1'b0, w);
    idle_inputs();
    arst_n = 1'b0;
    #2;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_y0", int'(y[0]), 0);
    chk("midreset_y2", int'(y[2]), 0);
    chk("midreset_cor_Y", int'(cor_Y), 0);
    chk("midreset_out_eof", int'(out_eof), 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #2 chk("in_ready_after_midreset", int'(in_ready), 1);
    send_block(3, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meas_gen.md
Name: meas_gen

Overview:
- Upstream stage of meas_pred: turns a raster of 4x4 pixel blocks into compressive measurements.
- Accepts one block row (BLK_N pixels) per handshake and accumulates the MEA_N signed measurements y = A·x.
- Emits each finished block's measurements with its block coordinates (cor_X, cor_Y), in the form meas_pred consumes.
- Double-buffered: the next block accumulates while the previous result waits on back-pressure.

Parameters:
- BLK_N, 4, block edge in pixels.
- PIX_N, BLK_N*BLK_N, pixels per block.
- MEA_N, PIX_N/2, measurements per block.
- PIX_WID, 8, unsigned pixel width.
- MEA_WID, $clog2(PIX_N)+PIX_WID, measurement magnitude width; outputs are MEA_WID+1 bits signed.
- PIC_WID, 13, picture width coordinate bits.
- PIC_HT, 13, picture height coordinate bits.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  row valid.
- in_ready  out  1  row accepted when in_valid&&in_ready.
- in_sof  in  1  first row of a frame; qualified by in_valid.
- pix  in  PIX_WID x BLK_N  unsigned pixels of one block row, index c=0..3 left to right.
- pic_w_blk  in  PIC_WID-$clog2(BLK_N)  last block column index (blocks-1); static within a frame.
- pic_h_blk  in  PIC_HT-$clog2(BLK_N)  last block row index; static within a frame.
- out_valid  out  1  measurement set valid.
- out_ready  in  1  consumer accepts.
- y  out  signed MEA_WID+1 x MEA_N  measurements.
- cor_X  out  PIC_WID-$clog2(BLK_N)  block column of y.
- cor_Y  out  PIC_HT-$clog2(BLK_N)  block row of y.
- out_eof  out  1  y is the last block of the frame.

Behaviour:
- Matrix: row vectors h0=[1,1,1,1], h1=[1,0,0,-1], h2=[1,-1,-1,1], h3=[0,-1,1,0]. Pixel (r,c) weight for measurement m is hc[m][c]*hr[m][r] with (hc,hr) per m = (h0,h0),(h1,h0),(h2,h0),(h3,h0),(h0,h1),(h1,h1),(h0,h2),(h0,h3). Weights are only -1/0/+1, so the datapath uses add/sub only, no multipliers.
- Row accumulation: row_cnt counts 0..3. Each accepted row adds hr[m][row_cnt]*sum_c(hc[m][c]*pix[c]) into acc[m], computed at full signed width. On row 0, acc is loaded rather than added. No saturation is needed; |y| <= 16*255 fits MEA_WID+1.
- Completion: on acceptance of row 3, the final sums, bx/by and eof are registered into the output register in the same edge; out_valid=1 the next cycle. Latency is 1 cycle from the last row handshake to out_valid.
- in_ready = (row_cnt!=3) || !out_valid || out_ready. Rows 0..2 are never stalled by the output.
- Output hold: y, cor_X, cor_Y and out_eof are stable while out_valid && !out_ready. out_valid clears on handshake unless a new block loads in the same cycle; in that case it stays 1 with the new data.
- Block counters bx/by advance on each completed block:
  - bx==pic_w_blk -> bx=0 and by++.
  - by==pic_h_blk at that point -> by=0 and out_eof=1 for that block.
- in_sof: when accepted, bx, by and row_cnt are forced to 0 and the row is treated as row 0. Any partially accumulated block is discarded with no output.
- Reset: row_cnt, bx, by, acc, y, cor_X, cor_Y = 0; out_valid=0, out_eof=0. in_ready=1 from the first cycle after reset. Reset mid-block drops that block.
- Simultaneous events:
  - Output handshake and row-3 load in the same cycle: the new block is loaded.
  - in_sof on row 3 position: the partial block is discarded (sof wins).

Decomposition:
- Package meas_pkg holds:
  - the hc/hr coefficient tables as localparam arrays of 2-bit signed;
  - MEA_WID, MEA_N, BLK_N defaults;
  - typedefs meas_t (signed MEA_WID+1), pix_row_t and blk_coord_t.
- One sub-module, meas_row_mac: combinational per-row weighted sum for all m, instantiated once.

Test Plan:
- All pixels 128, one block with no back-pressure -> y=[2048,0,0,0,0,0,0,0], cor=(0,0), out_valid exactly 1 cycle after the 4th row.
- Every row pix=[0,10,20,30] -> y=[240,-120,0,40,0,0,0,0].
- out_ready=0 for 10 cycles while a second block streams -> in_ready drops only at that block's row 3; first y is held unchanged; both blocks are delivered in order.
- pic_w_blk=2, pic_h_blk=1, 6 blocks -> cor sequence (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); out_eof only on the 6th; then wraps to (0,0).
- in_sof asserted on a row while row_cnt==2 -> partial block dropped; the next output is computed from the 4 rows starting at sof, with cor=(0,0).
- arst_n pulsed low after 2 rows -> all outputs 0, no spurious out_valid; the next 4 rows produce a correct block at (0,0).
